// File: rtl/fcvt32.sv
// Multi-cycle int32 <-> fp32 converter with valid/ready handshakes on both sides.
// Define FCVT32_FLAGS_EN to compile in invalid/inexact detection; otherwise flags reads 2'b00.
module fcvt32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mode,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  flags
);

    typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

    state_e      state_q, state_d;
    logic        mode_q;
    logic [31:0] in_q;
    logic [31:0] norm_q;
    logic [7:0]  exp_q;
    logic        sign_q;
    logic        zero_q;
    logic        nan_q;
    logic        inf_q;
    logic        ovf_q;
    logic        minneg_q;
    logic        tiny_q;
    logic [31:0] out_data_q;

    function automatic logic [5:0] clz32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n = 6'(31 - i);
        end
        return n;
    endfunction

    // NORM-stage combinational analysis of the latched operand
    logic [31:0] mag;
    logic [5:0]  lzc;
    logic [31:0] norm_shift;
    logic [7:0]  f_exp;
    logic [22:0] f_frac;

    always_comb begin
        mag        = in_q[31] ? (~in_q + 32'd1) : in_q;
        lzc        = clz32(mag);
        norm_shift = mag << lzc;
        f_exp      = in_q[30:23];
        f_frac     = in_q[22:0];
    end

    // ROUND-stage result computation
    logic        rnd_up;
    logic        rnd_carry;
    logic [22:0] i2f_mant;
    logic [7:0]  i2f_exp;
    logic [31:0] i2f_res;
    logic [2:0]  lsh;
    logic [4:0]  rsh;
    logic        left_region;
    logic [31:0] f2i_mag;
    logic [31:0] f2i_int;
    logic [31:0] f2i_res;

    always_comb begin
        rnd_up    = norm_q[7] & ((|norm_q[6:0]) | norm_q[8]);
        // Bit 31 is always set after normalisation, so carry-out needs only [30:8] all ones
        rnd_carry = (&norm_q[30:8]) & rnd_up;
        i2f_mant  = norm_q[30:8] + {22'd0, rnd_up};
        i2f_exp   = exp_q + {7'd0, rnd_carry};
        i2f_res   = zero_q ? 32'd0 : {sign_q, i2f_exp, i2f_mant};

        lsh         = 3'(exp_q - 8'd150);
        rsh         = 5'(8'd150 - exp_q);
        left_region = (exp_q >= 8'd150);
        f2i_mag     = left_region ? (norm_q << lsh) : (norm_q >> rsh);
        f2i_int     = sign_q ? (~f2i_mag + 32'd1) : f2i_mag;

        if (nan_q) begin
            f2i_res = 32'h7FFF_FFFF;
        end else if (inf_q || ovf_q) begin
            f2i_res = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (minneg_q) begin
            f2i_res = 32'h8000_0000;
        end else if (tiny_q) begin
            f2i_res = 32'd0;
        end else begin
            f2i_res = f2i_int;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid) state_d = StNorm;
            StNorm:  state_d = StRound;
            StRound: state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        out_data  = out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= 1'b0;
            in_q       <= 32'd0;
            norm_q     <= 32'd0;
            exp_q      <= 8'd0;
            sign_q     <= 1'b0;
            zero_q     <= 1'b0;
            nan_q      <= 1'b0;
            inf_q      <= 1'b0;
            ovf_q      <= 1'b0;
            minneg_q   <= 1'b0;
            tiny_q     <= 1'b0;
            out_data_q <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        mode_q <= mode;
                        in_q   <= in_data;
                    end
                end
                StNorm: begin
                    sign_q <= in_q[31];
                    if (!mode_q) begin
                        norm_q   <= norm_shift;
                        exp_q    <= 8'd158 - {2'b00, lzc};
                        zero_q   <= (mag == 32'd0);
                        nan_q    <= 1'b0;
                        inf_q    <= 1'b0;
                        ovf_q    <= 1'b0;
                        minneg_q <= 1'b0;
                        tiny_q   <= 1'b0;
                    end else begin
                        norm_q   <= {8'd0, (f_exp != 8'd0), f_frac};
                        exp_q    <= f_exp;
                        zero_q   <= (f_exp == 8'd0) && (f_frac == 23'd0);
                        nan_q    <= (f_exp == 8'hFF) && (f_frac != 23'd0);
                        inf_q    <= (f_exp == 8'hFF) && (f_frac == 23'd0);
                        // -2^31 is the one in-range value at exponent 158
                        ovf_q    <= (f_exp >= 8'd158) && (f_exp != 8'hFF) &&
                                    (in_q != 32'hCF00_0000);
                        minneg_q <= (in_q == 32'hCF00_0000);
                        tiny_q   <= (f_exp < 8'd127);
                    end
                end
                StRound: begin
                    out_data_q <= mode_q ? f2i_res : i2f_res;
                end
                default: ;
            endcase
        end
    end

`ifdef FCVT32_FLAGS_EN
    logic [31:0] rmask;
    logic        f2i_inexact;
    logic [1:0]  flags_d;
    logic [1:0]  flags_q;

    always_comb begin
        rmask = ~(32'hFFFF_FFFF << rsh);
        if (tiny_q) begin
            f2i_inexact = ~zero_q;
        end else if (left_region) begin
            f2i_inexact = 1'b0;
        end else begin
            f2i_inexact = |(norm_q & rmask);
        end

        if (!mode_q) begin
            flags_d = {1'b0, ~zero_q & (|norm_q[7:0])};
        end else if (nan_q || inf_q || ovf_q) begin
            flags_d = 2'b10;
        end else if (minneg_q) begin
            flags_d = 2'b00;
        end else begin
            flags_d = {1'b0, f2i_inexact};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 2'b00;
        end else if (state_q == StRound) begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`else
    assign flags = 2'b00;
`endif

endmodule

// File: tb/tb_fcvt32.sv
// Directed-vector bench for fcvt32: conversions, saturation, latency, backpressure, async reset.
module tb_fcvt32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  flags;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fcvt32 u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flags     (flags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    // Flags are hard-wired to zero when the flag logic is compiled out
    function automatic logic [31:0] eflags(input logic [1:0] f);
`ifdef FCVT32_FLAGS_EN
        return {30'd0, f};
`else
        return (f == 2'b11) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic start(input logic m, input logic [31:0] d);
        int waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        mode     = m;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mode     = ~m;
        in_data  = ~d;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic run_vec(input string tag, input logic m, input logic [31:0] d,
                           input logic [31:0] r, input logic [1:0] f);
        int cyc;
        start(m, d);
        check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        wait_done(cyc);
        // DONE is reached two edges after the accept edge
        check({tag, "_lat"}, 32'(cyc), 32'd2);
        check({tag, "_data"}, out_data, r);
        check({tag, "_flags"}, {30'd0, flags}, eflags(f));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int cyc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        mode      = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_flags", {30'd0, flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // int32 -> fp32
        run_vec("i2f_one",    1'b0, 32'h0000_0001, 32'h3F80_0000, 2'b00);
        run_vec("i2f_m1",     1'b0, 32'hFFFF_FFFF, 32'hBF80_0000, 2'b00);
        run_vec("i2f_zero",   1'b0, 32'h0000_0000, 32'h0000_0000, 2'b00);
        run_vec("i2f_max",    1'b0, 32'h7FFF_FFFF, 32'h4F00_0000, 2'b01);
        run_vec("i2f_tie",    1'b0, 32'h0100_0001, 32'h4B80_0000, 2'b01);
        run_vec("i2f_min",    1'b0, 32'h8000_0000, 32'hCF00_0000, 2'b00);
        run_vec("i2f_1000",   1'b0, 32'h0000_03E8, 32'h447A_0000, 2'b00);

        // fp32 -> int32
        run_vec("f2i_pi",     1'b1, 32'h4049_0FDB, 32'h0000_0003, 2'b01);
        run_vec("f2i_m2p5",   1'b1, 32'hC020_0000, 32'hFFFF_FFFE, 2'b01);
        run_vec("f2i_negz",   1'b1, 32'h8000_0000, 32'h0000_0000, 2'b00);
        run_vec("f2i_half",   1'b1, 32'h3F00_0000, 32'h0000_0000, 2'b01);
        run_vec("f2i_one",    1'b1, 32'h3F80_0000, 32'h0000_0001, 2'b00);
        run_vec("f2i_big",    1'b1, 32'h4EFF_FFFF, 32'h7FFF_FF80, 2'b00);
        run_vec("f2i_nan",    1'b1, 32'h7FC0_0000, 32'h7FFF_FFFF, 2'b10);
        run_vec("f2i_2p31",   1'b1, 32'h4F00_0000, 32'h7FFF_FFFF, 2'b10);
        run_vec("f2i_ninf",   1'b1, 32'hFF80_0000, 32'h8000_0000, 2'b10);
        run_vec("f2i_m2p31",  1'b1, 32'hCF00_0000, 32'h8000_0000, 2'b00);
        run_vec("f2i_nbig",   1'b1, 32'hD000_0000, 32'h8000_0000, 2'b10);

        // Backpressure: result held while out_ready is low, new input refused
        start(1'b0, 32'h0000_0001);
        wait_done(cyc);
        check("bp_lat", 32'(cyc), 32'd2);
        in_valid = 1'b1;
        mode     = 1'b0;
        in_data  = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_data", out_data, 32'h3F80_0000);
            check("bp_flags", {30'd0, flags}, 32'd0);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("bp_no_ghost", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while in NORM discards the operand
        run_vec("pre_rst",    1'b0, 32'h0000_0005, 32'h40A0_0000, 2'b00);
        start(1'b1, 32'h4049_0FDB);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_data", out_data, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_flags", {30'd0, flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_quiet", {31'd0, out_valid}, 32'd0);
        run_vec("post_rst",   1'b1, 32'hC020_0000, 32'hFFFF_FFFE, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
